// File: rtl/sn74165_if.sv
// rtl/sn74165_if.sv - signal bundle for the SN74165 parallel-load serial-out shift register
// The bench drives the master side and the register drives the slave side.
interface sn74165_if #(
  parameter int WIDTH = 8
);
  logic             CLK;
  logic             CLK_INH;
  logic             SH_LD_N;
  logic             SER;
  logic [WIDTH-1:0] D;
  logic             QH;
  logic             QH_N;

  modport master (
    output CLK, CLK_INH, SH_LD_N, SER, D,
    input  QH, QH_N
  );

  modport slave (
    input  CLK, CLK_INH, SH_LD_N, SER, D,
    output QH, QH_N
  );
endinterface

// File: rtl/sn74165.sv
// rtl/sn74165.sv - SN74165 8-bit parallel-load, serial-out shift register on a fast clock
// The original CLK and CLK_INH are sampled as data and edge-detected against CLK_DRV.
module sn74165 #(
  parameter int WIDTH = 8
) (
  input  logic        CLK_DRV,
  input  logic        CLR_N,
  sn74165_if.slave    bus
);

  logic             w_gclk;
  logic             w_edge;
  logic [WIDTH-1:0] r_q;
  logic             r_gclk_prev;

  assign w_gclk = bus.CLK | bus.CLK_INH;
  assign w_edge = w_gclk & ~r_gclk_prev;

  // r_gclk_prev resets high so a gated clock already high at release is not an edge.
  always_ff @(posedge CLK_DRV or negedge CLR_N) begin
    if (!CLR_N) begin
      r_q         <= '0;
      r_gclk_prev <= 1'b1;
    end else begin
      r_gclk_prev <= w_gclk;
      if (!bus.SH_LD_N) begin
        r_q <= bus.D;
      end else if (w_edge) begin
        r_q <= {r_q[WIDTH-2:0], bus.SER};
      end
    end
  end

  assign bus.QH   = r_q[WIDTH-1];
  assign bus.QH_N = ~r_q[WIDTH-1];

endmodule

// File: tb/tb_sn74165.sv
// tb/tb_sn74165.sv - scoreboard bench for sn74165
// Stimulus pushes expected QH values; a monitor pops and checks them on the falling edge.
module tb_sn74165;

  logic clk_drv;
  logic clr_n;

  sn74165_if #(.WIDTH(8)) bus ();

  sn74165 #(.WIDTH(8)) dut (
    .CLK_DRV (clk_drv),
    .CLR_N   (clr_n),
    .bus     (bus)
  );

  typedef struct {
    string name;
    logic  v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk_drv = 1'b0;
  always #5 clk_drv = ~clk_drv;

  task automatic tick();
    @(posedge clk_drv);
    #1;
  endtask

  task automatic expect_qh(input string name, input logic v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic pulse();
    bus.CLK = 1'b1;
    tick();
    tick();
    bus.CLK = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_drv);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.QH !== e.v) begin
          n_err++;
          $display("FAIL %s: QH got %b need %b", e.name, bus.QH, e.v);
        end
        n_cmp++;
        if (bus.QH_N !== ~e.v) begin
          n_err++;
          $display("FAIL %s: QH_N got %b need %b", e.name, bus.QH_N, ~e.v);
        end
      end
    end
  end

  initial begin
    logic [7:0] t2_exp;
    logic [7:0] t3_exp;
    int         wait_cnt;
    t2_exp = 8'b0101_0010;
    t3_exp = 8'b0111_1100;

    // 1: reset then parallel load of A5
    clr_n       = 1'b0;
    bus.CLK     = 1'b0;
    bus.CLK_INH = 1'b0;
    bus.SH_LD_N = 1'b1;
    bus.SER     = 1'b0;
    bus.D       = 8'h00;
    tick();
    tick();
    expect_qh("reset", 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    bus.SH_LD_N = 1'b0;
    bus.D       = 8'hA5;
    tick();
    expect_qh("load_a5", 1'b1);
    bus.SH_LD_N = 1'b1;
    tick();
    expect_qh("load_hold", 1'b1);

    // 2: serial readout H..A, zeros follow
    for (int i = 0; i < 8; i++) begin
      pulse();
      expect_qh($sformatf("readout_%0d", i + 1), t2_exp[i]);
    end

    // 3: fill with ones, inhibit, then one shift from CLK_INH rising with CLK low
    bus.SER = 1'b1;
    for (int i = 0; i < 3; i++) pulse();
    expect_qh("fill3", 1'b0);
    bus.CLK = 1'b1;
    tick();
    tick();
    bus.CLK_INH = 1'b1;
    tick();
    bus.CLK = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) pulse();
    bus.CLK_INH = 1'b0;
    tick();
    tick();
    bus.CLK_INH = 1'b1;
    tick();
    tick();
    bus.CLK_INH = 1'b0;
    tick();
    tick();
    bus.SER = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulse();
      expect_qh($sformatf("drain_%0d", i + 1), t3_exp[i]);
    end

    // 4: load overrides edges; releasing load with CLK high gives no shift
    bus.SH_LD_N = 1'b0;
    bus.D       = 8'h80;
    tick();
    expect_qh("ovr_load", 1'b1);
    for (int i = 0; i < 3; i++) begin
      pulse();
      expect_qh($sformatf("ovr_pulse_%0d", i + 1), 1'b1);
    end
    bus.CLK = 1'b1;
    tick();
    bus.SH_LD_N = 1'b1;
    tick();
    tick();
    expect_qh("ovr_release", 1'b1);
    bus.CLK = 1'b0;
    tick();
    tick();
    bus.CLK = 1'b1;
    tick();
    expect_qh("ovr_next_edge", 1'b0);
    bus.CLK = 1'b0;
    tick();
    tick();

    // 5: reset released with CLK high must not shift
    bus.SER = 1'b1;
    bus.CLK = 1'b1;
    clr_n   = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
    tick();
    bus.CLK = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 7; i++) pulse();
    expect_qh("rel_hi_7", 1'b0);
    pulse();
    expect_qh("rel_hi_8", 1'b1);

    // 6: asynchronous clear between CLK_DRV edges
    bus.SER = 1'b0;
    pulse();
    expect_qh("pre_clr", 1'b1);
    tick();
    #1 clr_n = 1'b0;
    #1 expect_qh("async_clr", 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    expect_qh("post_clr", 1'b0);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain_scoreboard: left %0d need 0", sb.size());
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
